vector_regfile_mp: RTL and testbench

//  Parametrised multi-ported vector register file; next generation of the per-register 1R/1W arrays in core.
//  NUM_RD read ports and NUM_WR write ports span all NUM_VREG registers of VREG_DEPTH elements each.

---
 rtl/vector_regfile_mp_if.sv | 60 ++++++
 rtl/vector_regfile_mp.sv | 192 +++++++++++++++++++
 tb/tb_vector_regfile_mp.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_regfile_mp_if.sv
// -----------------------------------------------------------------------------
// vector_regfile_mp_if
//   Bundles the read and write port groups of the multi-ported vector register
//   file so the decode/execute side and the array connect through one handle.
//
// Handshake semantics (all groups):
//   There is no backpressure. A request (rd_req[p] / wr_en[w]) is sampled at
//   every rising clk edge and acted on in that same edge. rd_valid[p] is the
//   response strobe: it pulses for one cycle, the edge after the request.
//   wr_conflict[w] pulses for one cycle, the edge after a write that lost an
//   address collision and was dropped. While init_done=0 every request is
//   ignored and no strobe is produced.
//
// Signals (port p field at [p*W +: W]):
//   init_done    array cleared, ports live
//   rd_req       per-port read request           rd_reg / rd_idx  address
//   rd_valid     read strobe                     rd_data          read element
//   wr_en        per-port write request          wr_reg / wr_idx  address
//   wr_data      write element                   wr_mask          byte enables
//   wr_conflict  write dropped by collision
// Modports: master drives requests (decode/execute side), slave is the array.
// -----------------------------------------------------------------------------
interface vector_regfile_mp_if #(
    parameter int NUM_VREG   = 8,
    parameter int VREG_DEPTH = 64,
    parameter int ELEM_WIDTH = 64,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    localparam int RW = (NUM_VREG > 1) ? $clog2(NUM_VREG) : 1;
    localparam int IW = (VREG_DEPTH > 1) ? $clog2(VREG_DEPTH) : 1;
    localparam int BW = ELEM_WIDTH / 8;

    logic                         init_done;

    logic [NUM_RD-1:0]            rd_req;
    logic [NUM_RD*RW-1:0]         rd_reg;
    logic [NUM_RD*IW-1:0]         rd_idx;
    logic [NUM_RD-1:0]            rd_valid;
    logic [NUM_RD*ELEM_WIDTH-1:0] rd_data;

    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*RW-1:0]         wr_reg;
    logic [NUM_WR*IW-1:0]         wr_idx;
    logic [NUM_WR*ELEM_WIDTH-1:0] wr_data;
    logic [NUM_WR*BW-1:0]         wr_mask;
    logic [NUM_WR-1:0]            wr_conflict;

    modport master (
        output rd_req, rd_reg, rd_idx,
        output wr_en, wr_reg, wr_idx, wr_data, wr_mask,
        input  init_done, rd_valid, rd_data, wr_conflict
    );

    modport slave (
        input  rd_req, rd_reg, rd_idx,
        input  wr_en, wr_reg, wr_idx, wr_data, wr_mask,
        output init_done, rd_valid, rd_data, wr_conflict
    );
endinterface

// File: rtl/vector_regfile_mp.sv
// -----------------------------------------------------------------------------
// vector_regfile_mp
//   Multi-ported vector register file: NUM_RD read ports and NUM_WR write ports
//   over NUM_VREG registers of VREG_DEPTH elements. Byte-masked writes,
//   write-first bypass to same-cycle reads, fixed-priority collision handling
//   (lowest port wins) and a self-clearing init sequencer after reset.
//
// Ports:
//   clk_i        core clock
//   rst_n_i      asynchronous active-low reset
//   bus          vector_regfile_mp_if.slave (read/write port groups, init_done)
//   dbg_state_o  sequencer state: 0 = INIT (clearing), 1 = READY
// -----------------------------------------------------------------------------
module vector_regfile_mp #(
    parameter int NUM_VREG   = 8,
    parameter int VREG_DEPTH = 64,
    parameter int ELEM_WIDTH = 64,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    vector_regfile_mp_if.slave        bus,
    output logic                      dbg_state_o
);
    localparam int RW = (NUM_VREG > 1) ? $clog2(NUM_VREG) : 1;
    localparam int IW = (VREG_DEPTH > 1) ? $clog2(VREG_DEPTH) : 1;
    localparam int BW = ELEM_WIDTH / 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                        state_q;
    logic [IW-1:0]                 init_ptr_q;
    logic                          init_done_q;

    // Storage carries no reset; the init sequencer clears it element by element.
    logic [ELEM_WIDTH-1:0]         mem_q [NUM_VREG][VREG_DEPTH];

    logic [NUM_WR-1:0]             wr_live;
    logic [NUM_WR-1:0]             wr_lose;
    logic [NUM_WR-1:0]             wr_win;

    logic [ELEM_WIDTH-1:0]         rd_merge [NUM_RD];

    logic [NUM_RD-1:0]             rd_valid_q, rd_valid_d;
    logic [NUM_RD*ELEM_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [NUM_WR-1:0]             wr_conflict_q, wr_conflict_d;

    // A write is live when the array is ready, it has at least one byte enabled
    // and it targets an existing register. Zero-mask and out-of-range writes
    // never take part in collisions.
    always_comb begin
        wr_live = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_live[w] = init_done_q && bus.wr_en[w] && (|bus.wr_mask[w*BW +: BW]) &&
                         (int'(bus.wr_reg[w*RW +: RW]) < NUM_VREG);
        end
    end

    // Fixed priority: a live port loses if any lower-numbered live port hits
    // the same (reg, idx). Losers are dropped whole, no byte merging.
    always_comb begin
        wr_lose = '0;
        wr_win  = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int v = 0; v < w; v++) begin
                if (wr_live[v] && wr_live[w] &&
                    (bus.wr_reg[v*RW +: RW] == bus.wr_reg[w*RW +: RW]) &&
                    (bus.wr_idx[v*IW +: IW] == bus.wr_idx[w*IW +: IW])) begin
                    wr_lose[w] = 1'b1;
                end
            end
            wr_win[w] = wr_live[w] && !wr_lose[w];
        end
    end

    // Read path with write-first bypass: winning writes to the same address
    // are merged byte-wise over the stored value, so the read sees what the
    // entry will hold after this edge. Winners never share an address, so the
    // merge order between ports does not matter.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_merge[p] = '0;
            if (int'(bus.rd_reg[p*RW +: RW]) < NUM_VREG) begin
                rd_merge[p] = mem_q[bus.rd_reg[p*RW +: RW]][bus.rd_idx[p*IW +: IW]];
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_win[w] &&
                        (bus.wr_reg[w*RW +: RW] == bus.rd_reg[p*RW +: RW]) &&
                        (bus.wr_idx[w*IW +: IW] == bus.rd_idx[p*IW +: IW])) begin
                        for (int b = 0; b < BW; b++) begin
                            if (bus.wr_mask[w*BW + b]) begin
                                rd_merge[p][b*8 +: 8] = bus.wr_data[w*ELEM_WIDTH + b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // One small next-state block per element: cleared when the sequencer
    // points at this index, otherwise byte-merged from the winning write.
    for (genvar r = 0; r < NUM_VREG; r++) begin : g_reg
        for (genvar i = 0; i < VREG_DEPTH; i++) begin : g_elem
            logic [ELEM_WIDTH-1:0] elem_d;

            always_comb begin
                elem_d = mem_q[r][i];
                if (state_q == ST_INIT) begin
                    if (init_ptr_q == IW'(i)) begin
                        elem_d = '0;
                    end
                end else begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_win[w] &&
                            (bus.wr_reg[w*RW +: RW] == RW'(r)) &&
                            (bus.wr_idx[w*IW +: IW] == IW'(i))) begin
                            for (int b = 0; b < BW; b++) begin
                                if (bus.wr_mask[w*BW + b]) begin
                                    elem_d[b*8 +: 8] = bus.wr_data[w*ELEM_WIDTH + b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                mem_q[r][i] <= elem_d;
            end
        end
    end

    // Init sequencer. init_done is set on the same edge that clears the last
    // element, i.e. the VREG_DEPTH-th edge after reset release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + IW'(1);
                    if (init_ptr_q == IW'(VREG_DEPTH - 1)) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Read data only updates on an accepted read; otherwise it holds.
    always_comb begin
        rd_valid_d = bus.rd_req & {NUM_RD{init_done_q}};
        rd_data_d  = rd_data_q;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_valid_d[p]) begin
                rd_data_d[p*ELEM_WIDTH +: ELEM_WIDTH] = rd_merge[p];
            end
        end
        wr_conflict_d = wr_lose;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
            wr_conflict_q <= '0;
        end else begin
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign bus.init_done   = init_done_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.wr_conflict = wr_conflict_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_vector_regfile_mp.sv
module tb_vector_regfile_mp;
    localparam int NV = 8;
    localparam int ND = 64;
    localparam int EW = 64;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk;
    logic rst_n;
    logic dbg_state;
    int   n_checks = 0;
    int   n_errors = 0;

    vector_regfile_mp_if #(.NUM_VREG(NV), .VREG_DEPTH(ND), .ELEM_WIDTH(EW),
                           .NUM_RD(NR), .NUM_WR(NW)) vif ();

    vector_regfile_mp #(.NUM_VREG(NV), .VREG_DEPTH(ND), .ELEM_WIDTH(EW),
                        .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bus         (vif),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [EW-1:0]    m_mem [NV][ND];
    logic [NR*EW-1:0] m_rd;
    logic [NR-1:0]    e_rv;
    logic [NW-1:0]    e_cf;
    bit               m_ready;

    task automatic m_reset();
        for (int r = 0; r < NV; r++)
            for (int i = 0; i < ND; i++)
                m_mem[r][i] = '0;
        m_rd    = '0;
        e_rv    = '0;
        e_cf    = '0;
        m_ready = 1'b0;
    endtask

    // Applies this cycle's writes (first port to claim an address wins), then
    // serves reads from the updated array, which gives write-first behaviour.
    task automatic model_step();
        bit         taken [int];
        int         r;
        int         ix;
        int         key;
        logic [7:0] m;
        e_rv = '0;
        e_cf = '0;
        if (!m_ready) return;
        for (int w = 0; w < NW; w++) begin
            m   = vif.wr_mask[w*8 +: 8];
            r   = int'(vif.wr_reg[w*3 +: 3]);
            ix  = int'(vif.wr_idx[w*6 +: 6]);
            key = r * ND + ix;
            if (!vif.wr_en[w] || m == 8'h00 || r >= NV) continue;
            if (taken.exists(key)) begin
                e_cf[w] = 1'b1;
                continue;
            end
            taken[key] = 1'b1;
            for (int b = 0; b < 8; b++)
                if (m[b]) m_mem[r][ix][b*8 +: 8] = vif.wr_data[w*EW + b*8 +: 8];
        end
        for (int p = 0; p < NR; p++) begin
            if (vif.rd_req[p]) begin
                r  = int'(vif.rd_reg[p*3 +: 3]);
                ix = int'(vif.rd_idx[p*6 +: 6]);
                e_rv[p] = 1'b1;
                m_rd[p*EW +: EW] = (r < NV) ? m_mem[r][ix] : '0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        vif.rd_req  = '0;
        vif.rd_reg  = '0;
        vif.rd_idx  = '0;
        vif.wr_en   = '0;
        vif.wr_reg  = '0;
        vif.wr_idx  = '0;
        vif.wr_data = '0;
        vif.wr_mask = '0;
    endtask

    task automatic set_rd(input int p, input int r, input int ix);
        vif.rd_req[p]        = 1'b1;
        vif.rd_reg[p*3 +: 3] = 3'(r);
        vif.rd_idx[p*6 +: 6] = 6'(ix);
    endtask

    task automatic set_wr(input int w, input int r, input int ix,
                          input logic [EW-1:0] d, input logic [7:0] m);
        vif.wr_en[w]            = 1'b1;
        vif.wr_reg[w*3 +: 3]    = 3'(r);
        vif.wr_idx[w*6 +: 6]    = 6'(ix);
        vif.wr_data[w*EW +: EW] = d;
        vif.wr_mask[w*8 +: 8]   = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic exp_done;
        idle();
        m_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (vif.init_done !== 1'b0) begin
            n_errors++; $display("FAIL reset_init_done: got %b expected 0", vif.init_done);
        end
        n_checks++;
        if (vif.rd_valid !== 2'b00) begin
            n_errors++; $display("FAIL reset_rd_valid: got %b expected 00", vif.rd_valid);
        end
        n_checks++;
        if (vif.rd_data !== '0) begin
            n_errors++; $display("FAIL reset_rd_data: got %h expected 0", vif.rd_data);
        end
        n_checks++;
        if (vif.wr_conflict !== 2'b00) begin
            n_errors++; $display("FAIL reset_wr_conflict: got %b expected 00", vif.wr_conflict);
        end
        n_checks++;
        if (dbg_state !== 1'b0) begin
            n_errors++; $display("FAIL reset_state: got %b expected 0", dbg_state);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= ND; e++) begin
            tick();
            exp_done = (e == ND);
            n_checks++;
            if (vif.init_done !== exp_done) begin
                n_errors++; $display("FAIL init_done_edge%0d: got %b expected %b", e, vif.init_done, exp_done);
            end
        end
        m_ready = 1'b1;
        n_checks++;
        if (dbg_state !== 1'b1) begin
            n_errors++; $display("FAIL ready_state: got %b expected 1", dbg_state);
        end
        set_rd(0, 3, 10);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.rd_valid !== 2'b01) begin
            n_errors++; $display("FAIL t1_rd_valid: got %b expected 01", vif.rd_valid);
        end
        n_checks++;
        if (vif.rd_data[63:0] !== 64'h0) begin
            n_errors++; $display("FAIL t1_rd_data: got %h expected 0", vif.rd_data[63:0]);
        end
        tick();
        n_checks++;
        if (vif.rd_valid !== 2'b00) begin
            n_errors++; $display("FAIL t1_rd_valid_pulse: got %b expected 00", vif.rd_valid);
        end
    endtask

    task automatic test_write_read();
        set_wr(0, 2, 5, 64'h1122334455667788, 8'hFF);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.wr_conflict !== 2'b00) begin
            n_errors++; $display("FAIL t2_conflict: got %b expected 00", vif.wr_conflict);
        end
        set_rd(1, 2, 5);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.rd_valid !== 2'b10) begin
            n_errors++; $display("FAIL t2_rd_valid: got %b expected 10", vif.rd_valid);
        end
        n_checks++;
        if (vif.rd_data[127:64] !== 64'h1122334455667788) begin
            n_errors++; $display("FAIL t2_rd_data: got %h expected 1122334455667788", vif.rd_data[127:64]);
        end
    endtask

    task automatic test_masked_write();
        set_wr(1, 2, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        model_step();
        tick();
        idle();
        set_rd(0, 2, 5);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.rd_data[63:0] !== 64'h11223344AAAAAAAA) begin
            n_errors++; $display("FAIL t3_masked: got %h expected 11223344aaaaaaaa", vif.rd_data[63:0]);
        end
        // Port 1 was not read, so its data must still hold the T2 value.
        n_checks++;
        if (vif.rd_data[127:64] !== 64'h1122334455667788) begin
            n_errors++; $display("FAIL t3_hold: got %h expected 1122334455667788", vif.rd_data[127:64]);
        end
    endtask

    task automatic test_collision();
        set_wr(0, 1, 0, 64'h1, 8'hFF);
        set_wr(1, 1, 0, 64'h2, 8'hFF);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.wr_conflict !== 2'b10) begin
            n_errors++; $display("FAIL t4_conflict: got %b expected 10", vif.wr_conflict);
        end
        set_rd(0, 1, 0);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.wr_conflict !== 2'b00) begin
            n_errors++; $display("FAIL t4_conflict_pulse: got %b expected 00", vif.wr_conflict);
        end
        n_checks++;
        if (vif.rd_data[63:0] !== 64'h1) begin
            n_errors++; $display("FAIL t4_stored: got %h expected 1", vif.rd_data[63:0]);
        end
    endtask

    task automatic test_bypass();
        set_wr(0, 4, 7, 64'hDEAD, 8'hFF);
        set_wr(1, 4, 7, 64'hBEEF, 8'h00);
        set_rd(0, 4, 7);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.rd_valid[0] !== 1'b1) begin
            n_errors++; $display("FAIL t5_rd_valid: got %b expected 1", vif.rd_valid[0]);
        end
        n_checks++;
        if (vif.rd_data[63:0] !== 64'hDEAD) begin
            n_errors++; $display("FAIL t5_bypass: got %h expected dead", vif.rd_data[63:0]);
        end
        n_checks++;
        if (vif.wr_conflict !== 2'b00) begin
            n_errors++; $display("FAIL t5_zero_mask_conflict: got %b expected 00", vif.wr_conflict);
        end
    endtask

    task automatic test_back_to_back(input int n);
        for (int c = 0; c < n; c++) begin
            idle();
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 1) == 1)
                    set_rd(p, $urandom_range(0, 3), $urandom_range(0, 3));
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 2) != 0)
                    set_wr(w, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
                           ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                vif.wr_reg[5:3]  = vif.wr_reg[2:0];
                vif.wr_idx[11:6] = vif.wr_idx[5:0];
            end
            model_step();
            tick();
            n_checks++;
            if (vif.rd_valid !== e_rv) begin
                n_errors++; $display("FAIL rand_rd_valid c%0d: got %b expected %b", c, vif.rd_valid, e_rv);
            end
            n_checks++;
            if (vif.rd_data !== m_rd) begin
                n_errors++; $display("FAIL rand_rd_data c%0d: got %h expected %h", c, vif.rd_data, m_rd);
            end
            n_checks++;
            if (vif.wr_conflict !== e_cf) begin
                n_errors++; $display("FAIL rand_conflict c%0d: got %b expected %b", c, vif.wr_conflict, e_cf);
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        logic exp_done;
        idle();
        set_wr(0, 2, 5, 64'h0123456789ABCDEF, 8'hFF);
        model_step();
        tick();
        idle();
        set_rd(0, 2, 5);
        set_rd(1, 2, 5);
        model_step();
        tick();
        n_checks++;
        if (vif.rd_valid !== 2'b11) begin
            n_errors++; $display("FAIL t6_pre_valid: got %b expected 11", vif.rd_valid);
        end
        n_checks++;
        if (vif.rd_data[63:0] !== 64'h0123456789ABCDEF) begin
            n_errors++; $display("FAIL t6_pre_data: got %h expected 0123456789abcdef", vif.rd_data[63:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (vif.rd_valid !== 2'b00) begin
            n_errors++; $display("FAIL t6_async_valid: got %b expected 00", vif.rd_valid);
        end
        n_checks++;
        if (vif.init_done !== 1'b0) begin
            n_errors++; $display("FAIL t6_async_init_done: got %b expected 0", vif.init_done);
        end
        n_checks++;
        if (vif.rd_data !== '0) begin
            n_errors++; $display("FAIL t6_async_data: got %h expected 0", vif.rd_data);
        end
        #1 rst_n = 1'b1;
        m_reset();
        for (int e = 1; e <= ND; e++) begin
            idle();
            vif.rd_req = 2'b11;
            set_wr(0, $urandom_range(0, 7), $urandom_range(0, ND - 1), {$urandom, $urandom}, 8'hFF);
            set_wr(1, 2, 5, {$urandom, $urandom}, 8'hFF);
            tick();
            exp_done = (e == ND);
            n_checks++;
            if (vif.rd_valid !== 2'b00 || vif.wr_conflict !== 2'b00) begin
                n_errors++; $display("FAIL t6_init_ignore e%0d: got valid=%b conflict=%b expected 00/00",
                                     e, vif.rd_valid, vif.wr_conflict);
            end
            n_checks++;
            if (vif.init_done !== exp_done) begin
                n_errors++; $display("FAIL t6_init_done e%0d: got %b expected %b", e, vif.init_done, exp_done);
            end
        end
        m_ready = 1'b1;
        idle();
        set_rd(1, 2, 5);
        model_step();
        tick();
        idle();
        n_checks++;
        if (vif.rd_valid !== 2'b10) begin
            n_errors++; $display("FAIL t6_post_valid: got %b expected 10", vif.rd_valid);
        end
        n_checks++;
        if (vif.rd_data[127:64] !== 64'h0) begin
            n_errors++; $display("FAIL t6_cleared: got %h expected 0", vif.rd_data[127:64]);
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < NV * ND; k += 2) begin
            idle();
            set_rd(0, k / ND, k % ND);
            set_rd(1, (k + 1) / ND, (k + 1) % ND);
            model_step();
            tick();
            n_checks++;
            if (vif.rd_valid !== 2'b11 || vif.rd_data !== m_rd) begin
                n_errors++; $display("FAIL sweep k%0d: got valid=%b data=%h expected 11 %h",
                                     k, vif.rd_valid, vif.rd_data, m_rd);
            end
        end
        idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_collision();
        test_bypass();
        test_back_to_back(400);
        test_reset_midop();
        test_sweep();
        test_back_to_back(200);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
